imem_loader: RTL
================

Name: imem_loader

Overview:
- Byte-stream program loader that writes the instruction memory the single-cycle RISC-V core fetches from. It is the writer side of the core's instruction-fetch read path.
- Accepts a framed byte stream, assembles little-endian 32-bit words and issues one-cycle write strobes to the instruction-memory write port.
- Holds the core in reset until a frame loads and its checksum verifies.

Parameters:
ADDR_W, 6, instruction-memory word-address width (2^ADDR_W words; default covers PC 0x000-0x0FC)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a new frame from IDLE, DONE or ERR
byte_in  in  8  stream data byte
byte_valid  in  1  byte_in is valid this cycle
byte_ready  out  1  loader can accept a byte this cycle
imem_we  out  1  instruction-memory write strobe, one cycle per word
imem_addr  out  ADDR_W  word address of the write (byte address = imem_addr<<2)
imem_wdata  out  32  assembled instruction word
core_reset  out  1  reset to the core; high until a successful load
busy  out  1  frame in progress (LEN, DATA, CHECK)
done  out  1  last frame loaded and verified
error  out  1  last frame rejected

Behaviour:
- Frame format, in order:
  - length byte N = number of words.
  - 4*N data bytes, each word LSB first: byte0 -> wdata[7:0] ... byte3 -> wdata[31:24].
  - check byte C.
  - The frame is valid iff the XOR of N, all data bytes and C equals 8'h00.
- Byte transfer: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_ready = 1 only in LEN, DATA and CHECK. Bytes offered in any other state are ignored.
- States: IDLE, LEN, DATA, CHECK, DONE, ERR. Reset enters IDLE.
- IDLE/DONE/ERR + start -> LEN:
  - clear word counter, byte counter and XOR accumulator;
  - clear done and error;
  - assert core_reset.
- LEN + accepted byte:
  - latch N and XOR it into the accumulator.
  - N == 0 -> CHECK.
  - N > 2^ADDR_W -> ERR in the next cycle, and no writes occur.
  - otherwise -> DATA.
- DATA:
  - each accepted byte is placed into the assembly register at lane byte_cnt and XORed into the accumulator; byte_cnt wraps 3 -> 0.
  - The cycle after the 4th byte is accepted: imem_we = 1 for exactly one cycle, imem_addr = word counter, imem_wdata = assembled word. The word counter then increments.
  - After word N-1 is accepted -> CHECK.
  - A byte may be accepted in the same cycle as the previous word's write strobe, so full throughput is one byte per cycle.
- CHECK + accepted byte: (accumulator XOR C) == 0 -> DONE, else -> ERR.
- Status outputs by state:
  - DONE: core_reset = 0, done = 1, busy = 0.
  - ERR: core_reset = 1, error = 1, busy = 0. Words already written stay in memory, but the core is not released.
- start while busy is ignored. A frame is never restarted mid-stream.
- Reset values: state IDLE, byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, busy 0, done 0, error 0.
- Asynchronous reset mid-frame aborts immediately, with no partial strobe. The next frame must begin with start.
- imem_addr and imem_wdata are registered and hold their last value when imem_we = 0.
- The word counter is ADDR_W+1 bits so that N = 2^ADDR_W is legal. The final write goes to address 2^ADDR_W - 1 with no wrap.

Test Plan:
- Reset, no stimulus -> core_reset=1, byte_ready=0, imem_we=0, done=0, error=0. After start -> byte_ready=1, busy=1.
- Two-word load:
  - stimulus: start, then N=02; bytes 93 00 50 00 (word 00500093, addi x1,x0,5); bytes 13 01 A0 00 (word 00A00113); check byte C = XOR of all previous bytes.
  - required: imem_we pulses with (addr 0, data 00500093) then (addr 1, data 00A00113); done=1; core_reset=0; the core then fetches 00500093 at PC 0.
- Same frame with C flipped in bit 0 -> both writes occur, error=1, done=0, core_reset stays 1.
- N=0, C=00 -> DONE with no imem_we pulses. N=0x41 (ADDR_W=6) -> ERR after the length byte, with no imem_we pulses.
- byte_valid held high continuously -> one byte accepted per cycle; write strobes 4 cycles apart; no byte lost at a word boundary.
- Reset asserted after 6 data bytes of a 2-word frame -> all outputs return to reset values at once. Start with a fresh 1-word frame -> writes addr 0 only, done=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Byte-stream program loader for the instruction memory of the single-cycle
//   RISC-V core. A frame is: length byte N (words), 4*N data bytes (each word
//   LSB first), then one check byte chosen so the XOR of every frame byte is 0.
//   Assembled words are written through a one-cycle write strobe. The core is
//   held in reset until a frame has loaded and its check byte verified.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   one-cycle pulse, starts a frame from IDLE/DONE/ERR
//   byte_in      in   [7:0] stream byte
//   byte_valid   in   byte_in valid this cycle
//   byte_ready   out  loader accepts a byte this cycle (LEN/DATA/CHECK)
//   imem_we      out  instruction-memory write strobe, one cycle per word
//   imem_addr    out  [ADDR_W-1:0] word address of the write
//   imem_wdata   out  [31:0] assembled instruction word
//   core_reset   out  core reset, high until a successful load
//   busy         out  frame in progress (LEN/DATA/CHECK)
//   done         out  last frame loaded and verified
//   error        out  last frame rejected
//   dbg_state    out  [2:0] current FSM state, for observation only
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high. byte_ready depends only on the FSM state, never on
// byte_valid, so the sender may hold byte_valid high for one byte per cycle.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  // One extra bit so that N = 2^ADDR_W words can be counted without wrapping.
  localparam int CW    = ADDR_W + 1;
  localparam int MAX_N = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       n_q, n_d;
  logic [CW-1:0]       word_cnt_q, word_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          xor_q, xor_d;
  logic [31:0]         asm_q, asm_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                core_reset_q, busy_q, done_q, error_q;
  logic                accept;

  assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    xor_d      = xor_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          xor_d      = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          xor_d = xor_q ^ byte_in;
          // Truncation is safe: out-of-range lengths go to ERR and never use n_q.
          n_d   = CW'(byte_in);
          if (byte_in == 8'h00) begin
            state_d = S_CHECK;
          end else if (32'(byte_in) > MAX_N) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d                            = xor_q ^ byte_in;
          asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
          byte_cnt_d                       = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // The 4th byte goes straight into the write data so the strobe
            // lands the cycle after it is accepted.
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = {byte_in, asm_q[23:0]};
            word_cnt_d = word_cnt_q + CW'(1);
            if (word_cnt_q == n_q - CW'(1)) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = ((xor_q ^ byte_in) == 8'h00) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      xor_q        <= '0;
      asm_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      xor_q        <= xor_d;
      asm_q        <= asm_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      // Status is registered from the next state so the core reset is a clean
      // flop output rather than a decode of the state bits.
      core_reset_q <= (state_d != S_DONE);
      busy_q       <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHECK);
      done_q       <= (state_d == S_DONE);
      error_q      <= (state_d == S_ERR);
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign dbg_state  = state_q;

endmodule
